// File: rtl/debug_wb_master.sv
// debug_wb_master: single-outstanding command/response bridge to a Wishbone master port with ack timeout.
module debug_wb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic [7:0]  err_count
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
    state_t      state, state_n;
    logic [7:0]  timer, timer_n, err_n;
    logic        ready_n, cyc_n, we_n, rsp_valid_n, rsp_err_n;
    logic [31:0] adr_n, dat_n, rsp_dat_n;
    logic [3:0]  sel_n;
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            timer     <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            cmd_ready <= ready_n;
            wbm_cyc_o <= cyc_n;
            wbm_stb_o <= cyc_n;
            wbm_we_o  <= we_n;
            wbm_adr_o <= adr_n;
            wbm_dat_o <= dat_n;
            wbm_sel_o <= sel_n;
            timer     <= timer_n;
            rsp_valid <= rsp_valid_n;
            rsp_dat   <= rsp_dat_n;
            rsp_err   <= rsp_err_n;
            err_count <= err_n;
        end
    end
    // Every output is computed here as its next value and registered above.
    always_comb begin
        state_n     = state;
        ready_n     = cmd_ready;
        cyc_n       = wbm_cyc_o;
        we_n        = wbm_we_o;
        adr_n       = wbm_adr_o;
        dat_n       = wbm_dat_o;
        sel_n       = wbm_sel_o;
        timer_n     = timer;
        rsp_valid_n = rsp_valid;
        rsp_dat_n   = rsp_dat;
        rsp_err_n   = rsp_err;
        err_n       = err_count;
        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    state_n = BUS;
                    ready_n = 1'b0;
                    cyc_n   = 1'b1;
                    we_n    = cmd_we;
                    adr_n   = cmd_adr;
                    dat_n   = cmd_we ? cmd_dat : 32'd0;
                    sel_n   = cmd_sel;
                    timer_n = '0;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    state_n     = RESP;
                    cyc_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_dat_n   = wbm_we_o ? 32'd0 : wbm_dat_i;
                    rsp_err_n   = 1'b0;
                end else if (timer == LAST) begin
                    state_n     = RESP;
                    cyc_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_dat_n   = '0;
                    rsp_err_n   = 1'b1;
                    err_n       = err_count + 8'(err_count != 8'hFF);
                end else begin
                    timer_n = timer + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                    ready_n     = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_debug_wb_master.sv
// tb_debug_wb_master: directed stimulus, transaction-phase reference model checked every cycle, plus literal checks.
module tb_debug_wb_master;
    localparam int TO = 16;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b1, ack = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0, dat_i = '0;
    logic [3:0]  cmd_sel = '0;
    logic        cmd_ready, rsp_valid, rsp_err, cyc, stb, we;
    logic [31:0] rsp_dat, adr, dat_o;
    logic [3:0]  sel;
    logic [7:0]  err_count;
    int errors = 0, checks = 0;

    debug_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
        .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = on the bus, 2 = holding a response.
    // n counts strobe cycles of the current transaction starting at 1.
    int          ph = 0, n = 0, timeouts = 0;
    logic        m_ready = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [31:0] m_adr = '0, m_dat = '0, m_rdat = '0;
    logic [3:0]  m_sel = '0;
    always @(posedge clk) begin
        if (!rst_n) begin
            ph = 0; n = 0; timeouts = 0; m_ready = 0; m_err = 0; m_rdat = 0;
        end else begin
            if (ph == 1) begin
                if (ack) begin
                    ph = 2; m_err = 0; m_rdat = m_we ? 32'd0 : dat_i;
                end else if (n == TO) begin
                    ph = 2; m_err = 1; m_rdat = 0; timeouts++;
                end else n++;
            end else if (ph == 2) begin
                if (rsp_ready) ph = 0;
            end else if (m_ready && cmd_valid) begin
                ph = 1; n = 1; m_we = cmd_we; m_adr = cmd_adr;
                m_dat = cmd_we ? cmd_dat : 32'd0; m_sel = cmd_sel;
            end
            m_ready = (ph == 0);
        end
    end

    always @(negedge clk) begin
        chk("cmd_ready", cmd_ready, m_ready);
        chk("cyc", cyc, ph == 1);
        chk("stb", stb, ph == 1);
        chk("rsp_valid", rsp_valid, ph == 2);
        chk("rsp_dat", rsp_dat, m_rdat);
        chk("rsp_err", rsp_err, m_err);
        chk("err_count", err_count, timeouts > 255 ? 255 : timeouts);
        if (ph == 1) begin
            chk("wbm_we", we, m_we);
            chk("wbm_adr", adr, m_adr);
            chk("wbm_dat", dat_o, m_dat);
            chk("wbm_sel", sel, m_sel);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k = 0;
        cmd_valid = 1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        if (!cmd_ready) begin chk("send_wait", 0, 1); end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic pulse_ack(input logic [31:0] d);
        ack = 1; dat_i = d;
        @(negedge clk);
        ack = 0; dat_i = '0;
    endtask

    initial begin
        int cnt;
        logic [31:0] held;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1);

        send(1, 32'h8, 32'hA5A5_1234, 4'hF);
        chk("wr_adr", adr, 32'h8);
        chk("wr_dat", dat_o, 32'hA5A5_1234);
        chk("wr_sel", sel, 4'hF);
        @(negedge clk);
        pulse_ack(32'h5555_5555);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_dat", rsp_dat, 0);
        chk("wr_cyc_low", cyc, 0);
        @(negedge clk);

        send(0, 32'hC, 32'h1111_1111, 4'hF);
        chk("rd_dat_o_zero", dat_o, 0);
        pulse_ack(32'hDEAD_BEEF);
        chk("rd_latency_valid", rsp_valid, 1);
        chk("rd_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
        chk("rd_stb_low", stb, 0);
        @(negedge clk);

        send(0, 32'h4, 32'h0, 4'hF);
        cnt = 0;
        while (stb && cnt < 40) begin cnt++; @(negedge clk); end
        chk("to_stb_cycles", cnt, 16);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_dat", rsp_dat, 0);
        chk("to_err_count", err_count, 1);
        @(negedge clk);

        rsp_ready = 0;
        send(0, 32'h20, 32'h0, 4'h3);
        pulse_ack(32'h1234_5678);
        held = rsp_dat;
        chk("bp_rsp_dat", held, 32'h1234_5678);
        cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h24; cmd_dat = 32'h0BAD_F00D; cmd_sel = 4'h1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_stable", rsp_dat, held);
            chk("bp_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_released", rsp_valid, 0);
        chk("bp_not_yet", stb, 0);
        @(negedge clk);
        cmd_valid = 0;
        chk("bp_new_adr", adr, 32'h24);
        pulse_ack(32'h0);
        @(negedge clk);

        send(0, 32'h30, 32'h0, 4'hF);
        repeat (15) @(negedge clk);
        pulse_ack(32'hCAFE_F00D);
        chk("sim_err", rsp_err, 0);
        chk("sim_dat", rsp_dat, 32'hCAFE_F00D);
        chk("sim_err_count", err_count, 1);
        @(negedge clk);
        ack = 1; dat_i = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        ack = 0; dat_i = '0;
        chk("stray_stb", stb, 0);
        chk("stray_dat", rsp_dat, 32'hCAFE_F00D);
        chk("stray_err_count", err_count, 1);

        send(1, 32'h40, 32'h7777_7777, 4'hC);
        repeat (2) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("mid_rst_cyc", cyc, 0);
        chk("mid_rst_adr", adr, 0);
        chk("mid_rst_dat", dat_o, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_we", we, 0);
        chk("mid_rst_errs", err_count, 0);
        rst_n = 1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_valid", rsp_valid, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/debug_wb_master.md
DEBUG_WB_MASTER -- requirements
Module: debug_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of bus-phase cycles to wait for wbm_ack_i (legal range 2..255).
REQ-002 SHALL have port wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port wb_rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports cmd_adr  input  32, cmd_dat  input  32 and cmd_sel  input  4, carrying the target address, write data and byte enables.
REQ-008 SHALL have port rsp_valid  output  1  response available.
REQ-009 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-010 SHALL have ports rsp_dat  output  32 (read data, 0 for writes and errors) and rsp_err  output  1 (1 = timeout).
REQ-011 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each, the Wishbone master strobes.
REQ-012 SHALL have ports wbm_adr_o  output  32, wbm_dat_o  output  32 and wbm_sel_o  output  4, the Wishbone address, write data and byte selects.
REQ-013 SHALL have ports wbm_ack_i  input  1 and wbm_dat_i  input  32, the Wishbone slave acknowledge and read data.
REQ-014 SHALL have port err_count  output  8  saturating timeout count.

Function
REQ-015 SHALL implement FSM states IDLE, BUS and RESP, all outputs registered.
REQ-016 SHALL drive cmd_ready=1 only in IDLE, and accept at most one outstanding transaction.
REQ-017 SHALL, on an IDLE cycle with cmd_valid&&cmd_ready, latch cmd_we/adr/dat/sel and enter BUS, with wbm_cyc_o=wbm_stb_o=1 from the next cycle.
REQ-018 SHALL hold wbm_we_o/adr_o/dat_o/sel_o stable for the entire BUS phase; wbm_dat_o SHALL be 0 during reads.
REQ-019 SHALL clear the wait timer on BUS entry and increment it on each BUS cycle without wbm_ack_i.
REQ-020 SHALL, on a BUS cycle with wbm_ack_i=1: deassert cyc/stb on the next edge; capture rsp_dat=wbm_dat_i for reads, 0 for writes; set rsp_err=0; enter RESP.
REQ-021 SHALL, on a BUS cycle with no ack and timer==TIMEOUT_CYCLES-1: deassert cyc/stb; set rsp_dat=0 and rsp_err=1; increment err_count, saturating at 255; enter RESP.
REQ-022 SHALL let ack win when ack and timeout coincide in the same cycle.
REQ-023 SHALL keep cyc/stb low for at least one cycle between transactions, since the minimum ack-to-next-strobe gap is 2 cycles through RESP/IDLE.
REQ-024 SHALL assert rsp_valid throughout RESP and hold rsp_dat/rsp_err stable until rsp_ready; on rsp_valid&&rsp_ready SHALL enter IDLE and drop rsp_valid.
REQ-025 SHALL ignore wbm_ack_i and wbm_dat_i outside BUS, with no state or error change.
REQ-026 SHALL keep rsp_dat/rsp_err holding the last response value outside RESP.
REQ-027 SHALL yield a single-ack transaction latency of 2 cycles from cmd handshake to rsp_valid when ack comes on the first strobe cycle.

Reset
REQ-028 SHALL, on any edge with wb_rst_n_i=0, force state=IDLE, cmd_ready=0 during reset (1 on the first cycle after release), all wbm_*_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, timer=0, err_count=0.
REQ-029 SHALL make reset mid-BUS drop cyc/stb on that same edge and discard the pending response.

Verification
REQ-030 SHALL cover a write: cmd we=1 adr=0x8 dat=0xA5A5_1234 sel=0xF, slave acks after 1 cycle -> one strobe with those values, rsp_valid with rsp_err=0 and rsp_dat=0.
REQ-031 SHALL cover a read: adr=0xC, slave returns 0xDEAD_BEEF on ack -> rsp_dat=0xDEAD_BEEF, rsp_err=0, cyc/stb low the cycle after ack.
REQ-032 SHALL cover a timeout: read adr=0x4 with no ack and TIMEOUT_CYCLES=16 -> stb high exactly 16 cycles, then rsp_err=1, rsp_dat=0, err_count 0->1.
REQ-033 SHALL cover backpressure: rsp_ready held low 5 cycles -> rsp_valid/rsp_dat stable, cmd_ready=0, and a new cmd_valid is not accepted until after the response handshake.
REQ-034 SHALL cover simultaneous events: ack on cycle 16 of BUS -> success (rsp_err=0, err_count unchanged); a stray ack in IDLE -> no effect.
REQ-035 SHALL cover reset mid-BUS: wb_rst_n_i=0 on BUS cycle 3 -> all outputs 0 next edge, and no rsp_valid after reset release.
